// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle MIPS-32 subset core sharing one memory port for fetch and data.
// Each instruction walks FETCH/DECODE/execute/writeback states; HALT is absorbing and latches a trap cause.
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 0,
    parameter bit          DBG_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    input  logic [4:0]  i_dbg_addr,
    output logic [31:0] o_dbg_data,
    output logic [31:0] o_pc_out,
    output logic        o_halted,
    output logic [1:0]  o_trap_cause
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                           S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_WB_R = 4'd7,
                           S_WB_I = 4'd8, S_WB_MEM = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                           S_HALT = 4'd12;
    localparam logic [1:0]  T_ILLEGAL = 2'b01, T_ALIGN = 2'b10, T_BUS = 2'b11;
    localparam logic [31:0] TMO_LAST = 32'(MEM_TIMEOUT - 1);

    logic [3:0]  r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr, r_wait;
    logic [1:0]  r_trap;
    logic [31:0] r_regs [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wa;
    logic [31:0] w_imm, w_addr, w_alu_r, w_wd;
    logic [3:0]  w_dispatch;
    logic        w_funct_ok, w_wait_hit, w_mem_state, w_reg_we;

    assign w_op        = r_ir[31:26];
    assign w_rs        = r_ir[25:21];
    assign w_rt        = r_ir[20:16];
    assign w_rd        = r_ir[15:11];
    assign w_funct     = r_ir[5:0];
    assign w_imm       = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_addr      = r_a + w_imm;
    assign w_funct_ok  = w_funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    assign w_alu_r     = w_funct == 6'b100010 ? r_a - r_b :
                         w_funct == 6'b100100 ? r_a & r_b :
                         w_funct == 6'b100101 ? r_a | r_b :
                         w_funct == 6'b101010 ? {31'd0, $signed(r_a) < $signed(r_b)} : r_a + r_b;
    assign w_wait_hit  = (MEM_TIMEOUT > 0) && (r_wait == TMO_LAST);
    assign w_mem_state = r_state == S_FETCH || r_state == S_MEM_RD || r_state == S_MEM_WR;
    assign w_reg_we    = r_state == S_WB_R || r_state == S_WB_I || r_state == S_WB_MEM;
    assign w_wa        = r_state == S_WB_R ? w_rd : w_rt;
    assign w_wd        = r_state == S_WB_MEM ? r_mdr : r_alu;

    always_comb begin
        case (w_op)
            6'b000000:            w_dispatch = w_funct_ok ? S_EXEC_R : S_HALT;
            6'b100011, 6'b101011: w_dispatch = S_MEM_ADDR;
            6'b000100, 6'b000101: w_dispatch = S_BRANCH;
            6'b001000:            w_dispatch = S_EXEC_I;
            6'b000010:            w_dispatch = S_JUMP;
            default:              w_dispatch = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_reg_we && w_wa != 5'd0) begin
            r_regs[w_wa] <= w_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
            r_trap  <= 2'b00;
            r_wait  <= '0;
        end else begin
            // Wait counter restarts whenever an access completes or the core leaves the memory states
            r_wait <= (w_mem_state && !i_mem_ack) ? r_wait + 32'd1 : '0;
            case (r_state)
                S_FETCH: begin
                    if (r_pc[1:0] != 2'b00) begin
                        r_state <= S_HALT;
                        r_trap  <= T_ALIGN;
                    end else if (i_mem_ack) begin
                        r_ir    <= i_mem_rdata;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_DECODE;
                    end else if (w_wait_hit) begin
                        r_state <= S_HALT;
                        r_trap  <= T_BUS;
                    end
                end
                S_DECODE: begin
                    r_a     <= r_regs[w_rs];
                    r_b     <= r_regs[w_rt];
                    r_alu   <= r_pc + {w_imm[29:0], 2'b00};
                    r_state <= w_dispatch;
                    if (w_dispatch == S_HALT) r_trap <= T_ILLEGAL;
                end
                S_EXEC_R: begin
                    r_alu   <= w_alu_r;
                    r_state <= S_WB_R;
                end
                S_EXEC_I: begin
                    r_alu   <= w_addr;
                    r_state <= S_WB_I;
                end
                S_MEM_ADDR: begin
                    r_alu <= w_addr;
                    if (w_addr[1:0] != 2'b00) begin
                        r_state <= S_HALT;
                        r_trap  <= T_ALIGN;
                    end else begin
                        r_state <= w_op == 6'b100011 ? S_MEM_RD : S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    if (i_mem_ack) begin
                        r_mdr   <= i_mem_rdata;
                        r_state <= S_WB_MEM;
                    end else if (w_wait_hit) begin
                        r_state <= S_HALT;
                        r_trap  <= T_BUS;
                    end
                end
                S_MEM_WR: begin
                    if (i_mem_ack) begin
                        r_state <= S_FETCH;
                    end else if (w_wait_hit) begin
                        r_state <= S_HALT;
                        r_trap  <= T_BUS;
                    end
                end
                S_WB_R, S_WB_I, S_WB_MEM: r_state <= S_FETCH;
                S_BRANCH: begin
                    // beq takes the branch on a zero difference, bne on a non-zero one
                    if (((r_a - r_b) == 32'd0) == (w_op == 6'b000100)) r_pc <= r_alu;
                    r_state <= S_FETCH;
                end
                S_JUMP: begin
                    r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    r_state <= S_FETCH;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Gating with rst_n drops the request the instant reset asserts
    assign o_mem_req    = rst_n && ((r_state == S_FETCH && r_pc[1:0] == 2'b00) ||
                                    r_state == S_MEM_RD || r_state == S_MEM_WR);
    assign o_mem_we     = r_state == S_MEM_WR;
    assign o_mem_addr   = r_state == S_FETCH ? r_pc : r_alu;
    assign o_mem_wdata  = r_b;
    assign o_dbg_data   = (DBG_EN && i_dbg_addr != 5'd0) ? r_regs[i_dbg_addr] : '0;
    assign o_pc_out     = r_pc;
    assign o_halted     = r_state == S_HALT;
    assign o_trap_cause = r_trap;
endmodule

// File: doc/mc_cpu_core.md
MC_CPU_CORE -- requirements
Module: mc_cpu_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC value loaded on reset.
REQ-002 Parameter MEM_TIMEOUT, default 0, sets the max wait cycles per memory access; 0 disables the timeout.
REQ-003 Parameter DBG_EN, default 1; when 1 the debug read port is live, when 0 dbg_data SHALL be tied to 0.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 mem_req  out  1  memory access request.
REQ-007 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 mem_addr  out  32  byte address, word-aligned.
REQ-009 mem_wdata  out  32  store data.
REQ-010 mem_rdata  in  32  read data; valid in the cycle mem_ack=1.
REQ-011 mem_ack  in  1  access complete; may assert in the same cycle as mem_req.
REQ-012 dbg_addr  in  5  register-file debug read index.
REQ-013 dbg_data  out  32  combinational read of register dbg_addr.
REQ-014 pc_out  out  32  current PC.
REQ-015 halted  out  1  core stopped in HALT.
REQ-016 trap_cause  out  2  00 none, 01 illegal opcode, 10 misaligned address, 11 bus timeout.

Function
REQ-017 The ISA SHALL be MIPS-32 subset: R-type add/sub/and/or/slt (op 000000), lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
REQ-018 FSM states SHALL be: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, HALT.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on a sampled mem_ack, load IR from mem_rdata, set PC<=PC+4, go to DECODE; otherwise hold FETCH with all outputs stable.
REQ-020 DECODE: latch A=R[rs], B=R[rt], ALUOut=PC+(sext(imm)<<2); then dispatch on opcode; an unknown opcode or R-type funct SHALL go to HALT with trap_cause=01.
REQ-021 EXEC_R then WB_R writes R[rd]; EXEC_I then WB_I writes R[rt]=A+sext(imm); MEM_ADDR computes A+sext(imm).
REQ-022 If the MEM_ADDR result has bits [1:0] != 0, or PC[1:0] != 0 at FETCH, the core SHALL go to HALT with trap_cause=10 and issue no request.
REQ-023 MEM_RD: read request held until ack, then MDR<=mem_rdata, go to WB_MEM, write R[rt]; MEM_WR: mem_we=1, mem_wdata=B, held until ack, then go to FETCH.
REQ-024 BRANCH: compute A-B; beq taken on zero, bne taken on non-zero; taken sets PC<=ALUOut; then go to FETCH.
REQ-025 JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; then go to FETCH.
REQ-026 With zero-wait ack, cycles per instruction SHALL be: R/addi 4, lw 5, sw 4, beq/bne 3, j 3; each wait cycle adds exactly 1.
REQ-027 Writes to R0 SHALL be discarded; reads of R0 SHALL return 0, including on the debug port.
REQ-028 A register write and a dbg_addr read of the same index in the same cycle SHALL return the old value; the new value is visible the next cycle.
REQ-029 Arithmetic SHALL be 32-bit wrap-around; overflow is ignored (no trap); slt is signed.
REQ-030 Timeout: if MEM_TIMEOUT>0, a wait counter SHALL clear on entry to each memory state and increment per un-acked cycle; reaching MEM_TIMEOUT SHALL go to HALT with trap_cause=11 and deassert mem_req.
REQ-031 HALT is absorbing: mem_req=0, halted=1; only reset exits it.
REQ-032 mem_req SHALL be 0 in every state other than FETCH, MEM_RD, and MEM_WR.

Reset
REQ-033 On rst=0, asynchronously: state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all registers=0, halted=0, trap_cause=00, mem_req=0.
REQ-034 mem_req SHALL first assert in the first clock after rst is deasserted.
REQ-035 Reset asserted mid-access SHALL drop mem_req immediately; late acks SHALL be ignored.

Verification
V-1 Memory holds addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 with zero-wait ack -> after 12 cycles, dbg_addr=3 gives dbg_data=12, pc_out=0x0C.
V-2 sw $3,0x40($0); lw $4,0x40($0) with ack delayed 3 cycles -> mem_we=1 with mem_addr=0x40 and mem_wdata=12; R4=12; each access takes 3 extra cycles.
V-3 beq $1,$1,-1 at 0x10 -> PC returns to 0x10 every 3 cycles; bne $1,$1,+4 -> PC=0x14.
V-4 Opcode 111111 -> halted=1, trap_cause=01, mem_req stays 0; lw at address 0x41 -> trap_cause=10.
V-5 MEM_TIMEOUT=8 and ack never returned -> halted after exactly 8 wait cycles, trap_cause=11.
V-6 rst pulse in the MEM_RD wait with ack arriving later -> PC=RESET_PC, no register write, fetch restarts.
